// File: rtl/rx_module.sv
// -----------------------------------------------------------------------------
// rx_module -- UART receiver (8N1, optional even parity)
//
// Recovers frames from an asynchronous serial line: one start bit (0), eight
// data bits LSB first, one stop bit (1). Each correctly framed byte is
// presented on rx_data together with a one-cycle rx_done pulse. Bit timing is
// derived from the BPS (clocks per bit) parameter; no external baud tick.
//
// Optional build macro: RX_PARITY_EN
//   defined   -> 11-bit frame with an even-parity bit after data bit 7;
//                a bad parity bit yields a parity_err pulse instead of rx_done.
//   undefined -> 10-bit frame, parity_err tied to 0.
//
// Parameters:
//   BPS        clocks per bit (default 434 = 50 MHz / 115200), minimum 8
//
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous reset, ACTIVE HIGH (1 = reset)
//   rx_en_sig  in   receive enable; 0 holds the receiver idle
//   rx_pin     in   asynchronous serial line, idle high
//   rx_data    out  [7:0] last correctly framed byte
//   rx_done    out  one-cycle pulse when rx_data has been updated
//   frame_err  out  one-cycle pulse when the stop bit is sampled as 0
//   parity_err out  one-cycle pulse on a parity mismatch (0 without RX_PARITY_EN)
// -----------------------------------------------------------------------------
module rx_module #(
   parameter logic [12:0] BPS = 13'd434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_en_sig,
   input  logic       rx_pin,
   output logic [7:0] rx_data,
   output logic       rx_done,
   output logic       frame_err,
   output logic       parity_err
);

   // Last count of a full bit, and last count of the half bit used to find
   // the middle of the start bit.
   localparam logic [15:0] BIT_LAST  = 16'(BPS) - 16'd1;
   localparam logic [15:0] HALF_LAST = (16'(BPS) >> 1) - 16'd1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef RX_PARITY_EN
      PARITY,
`endif
      STOP,
      DONE
   } state_t;

   // Input path: two synchroniser flops, then one more for edge detection.
   logic sync_meta;
   logic sync_line;
   logic line_prev;
   logic fall_edge;

   state_t      state,     state_nxt;
   logic [15:0] cnt,       cnt_nxt;
   logic [2:0]  idx,       idx_nxt;
   logic [7:0]  shift,     shift_nxt;
   logic [7:0]  data_nxt;
   logic        ferr_nxt;
`ifdef RX_PARITY_EN
   logic        par_bit,   par_nxt;
   logic        perr_nxt;
`endif

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every flop samples the values from before the clock edge.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         sync_meta <= 1'b1;
         sync_line <= 1'b1;
         line_prev <= 1'b1;
      end else begin
         sync_meta <= rx_pin;
         sync_line <= sync_meta;
         line_prev <= sync_line;
      end
   end

   assign fall_edge = line_prev & ~sync_line;

   // Next-state and datapath logic.
   always_comb begin
      // NOTE: every variable gets its default first; any path that does not
      // assign it keeps the default instead of inferring a latch.
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      shift_nxt = shift;
      data_nxt  = rx_data;
      ferr_nxt  = 1'b0;
`ifdef RX_PARITY_EN
      par_nxt   = par_bit;
      perr_nxt  = 1'b0;
`endif

      if (!rx_en_sig) begin
         // Disable discards any frame in flight; rx_data is left untouched.
         state_nxt = IDLE;
         cnt_nxt   = '0;
         idx_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (fall_edge) begin
                  state_nxt = START;
                  cnt_nxt   = '0;
               end
            end

            START: begin
               if (cnt == HALF_LAST) begin
                  // Line back high at mid start bit: a glitch, not a frame.
                  state_nxt = sync_line ? IDLE : DATA;
                  cnt_nxt   = '0;
                  idx_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 16'd1;
               end
            end

            DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt_nxt        = '0;
                  shift_nxt[idx] = sync_line;
                  idx_nxt        = idx + 3'd1;
                  if (idx == 3'd7) begin
`ifdef RX_PARITY_EN
                     state_nxt = PARITY;
`else
                     state_nxt = STOP;
`endif
                  end
               end else begin
                  cnt_nxt = cnt + 16'd1;
               end
            end

`ifdef RX_PARITY_EN
            PARITY: begin
               if (cnt == BIT_LAST) begin
                  cnt_nxt   = '0;
                  par_nxt   = sync_line;
                  state_nxt = STOP;
               end else begin
                  cnt_nxt = cnt + 16'd1;
               end
            end
`endif

            STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt_nxt = '0;
                  if (!sync_line) begin
                     // Break or stuck-low line: flag once, then wait for a
                     // fresh high-to-low transition in IDLE.
                     ferr_nxt  = 1'b1;
                     state_nxt = IDLE;
                  end
`ifdef RX_PARITY_EN
                  else if (^shift ^ par_bit) begin
                     perr_nxt  = 1'b1;
                     state_nxt = IDLE;
                  end
`endif
                  else begin
                     data_nxt  = shift;
                     state_nxt = DONE;
                  end
               end else begin
                  cnt_nxt = cnt + 16'd1;
               end
            end

            DONE: begin
               state_nxt = IDLE;
            end

            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         shift     <= '0;
         rx_data   <= '0;
         frame_err <= 1'b0;
`ifdef RX_PARITY_EN
         par_bit    <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         idx       <= idx_nxt;
         shift     <= shift_nxt;
         rx_data   <= data_nxt;
         frame_err <= ferr_nxt;
`ifdef RX_PARITY_EN
         par_bit    <= par_nxt;
         parity_err <= perr_nxt;
`endif
      end
   end

   // rx_data is loaded on the edge that enters DONE, so the pulse lines up
   // with the new byte.
   assign rx_done = (state == DONE);

`ifndef RX_PARITY_EN
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_rx_module.sv
// -----------------------------------------------------------------------------
// tb_rx_module -- self-checking bench for rx_module (BPS = 16).
// Frames are driven bit by bit on rx_pin; a monitor logs every output pulse
// (kind, rx_data, cycle) into a queue that is compared with the expected
// events produced by a frame-level model or by a vector table.
// -----------------------------------------------------------------------------
module tb_rx_module;

   localparam int BPS = 16;
   localparam int H   = BPS / 2;
`ifdef RX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int LAT = (FRAME_BITS - 1) * BPS + H + 4;

   typedef enum logic [1:0] {EV_DONE, EV_FERR, EV_PERR} ev_kind_t;

   typedef struct {
      ev_kind_t   kind;
      logic [7:0] data;
      int         cyc;
   } ev_t;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      ev_kind_t   exp_kind;
      logic [7:0] exp_data;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       rx_en_sig = 1'b1;
   logic       rx_pin = 1'b1;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       frame_err;
   logic       parity_err;

   rx_module #(.BPS(13'd16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_en_sig  (rx_en_sig),
      .rx_pin     (rx_pin),
      .rx_data    (rx_data),
      .rx_done    (rx_done),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   ev_t        obs_q[$];
   ev_t        exp_q[$];
   int         n_pass = 0;
   int         n_checks = 0;
   int         overlap_cnt = 0;
   int         last_start = 0;
   logic [7:0] last_good = 8'h00;
`ifdef RX_PARITY_EN
   logic       par_flip = 1'b0;
`endif

   // Monitor: sampled on the falling edge, away from the DUT's active edge.
   logic prev_done = 1'b0, prev_ferr = 1'b0, prev_perr = 1'b0;
   always @(negedge clk) begin
      ev_t e;
      e.cyc  = cyc;
      e.data = rx_data;
      if (rx_done === 1'b1)    begin e.kind = EV_DONE; obs_q.push_back(e); end
      if (frame_err === 1'b1)  begin e.kind = EV_FERR; obs_q.push_back(e); end
      if (parity_err === 1'b1) begin e.kind = EV_PERR; obs_q.push_back(e); end
      if ((rx_done === 1'b1 && frame_err === 1'b1) ||
          (rx_done === 1'b1 && parity_err === 1'b1) ||
          (frame_err === 1'b1 && parity_err === 1'b1))
         overlap_cnt <= overlap_cnt + 1;
      if ((rx_done === 1'b1 && prev_done) || (frame_err === 1'b1 && prev_ferr) ||
          (parity_err === 1'b1 && prev_perr))
         overlap_cnt <= overlap_cnt + 1;
      prev_done <= (rx_done === 1'b1);
      prev_ferr <= (frame_err === 1'b1);
      prev_perr <= (parity_err === 1'b1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_checks++;
      if (act >= lo && act <= hi) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
   endtask

   // Frame-level reference: what one transmitted frame must produce.
   function automatic void model_frame(input logic [7:0] data, input logic stop);
      ev_t e;
      e.cyc = 0;
      if (!stop) begin
         e.kind = EV_FERR;
         e.data = last_good;
      end
`ifdef RX_PARITY_EN
      else if (par_flip) begin
         e.kind = EV_PERR;
         e.data = last_good;
      end
`endif
      else begin
         e.kind    = EV_DONE;
         e.data    = data;
         last_good = data;
      end
      exp_q.push_back(e);
   endfunction

   // Drives one frame. abort_kind 1 drops rx_en_sig, 2 pulses reset, in the
   // middle of line bit abort_bit (0 = start bit).
   task automatic send_frame(input logic [7:0] data, input logic stop,
                             input int abort_bit, input int abort_kind);
      logic [10:0] bits;
`ifdef RX_PARITY_EN
      bits = {stop, ^data ^ par_flip, data, 1'b0};
`else
      bits = {1'b1, stop, data, 1'b0};
`endif
      last_start = cyc;
      for (int i = 0; i < FRAME_BITS; i++) begin
         rx_pin = bits[i];
         for (int j = 0; j < BPS; j++) begin
            if (i == abort_bit && j == H) begin
               if (abort_kind == 1) rx_en_sig = 1'b0;
               if (abort_kind == 2) rst_n = 1'b1;
            end
            if (i == abort_bit && j == H + 1 && abort_kind == 2) rst_n = 1'b0;
            @(negedge clk);
         end
      end
      rx_en_sig = 1'b1;
   endtask

   task automatic idle_bits(input int n);
      rx_pin = 1'b1;
      repeat (n * BPS) @(negedge clk);
   endtask

   task automatic compare_events(input string name);
      check({name, " event count"}, 32'(obs_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         check($sformatf("%s ev%0d kind", name, i), 32'(obs_q[i].kind), 32'(exp_q[i].kind));
         check($sformatf("%s ev%0d rx_data", name, i), 32'(obs_q[i].data), 32'(exp_q[i].data));
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   vec_t tbl[6];

   initial begin
      logic [7:0] d;
      logic       s;

      tbl[0] = '{8'h5A, 1'b1, EV_DONE, 8'h5A};
      tbl[1] = '{8'hC3, 1'b0, EV_FERR, 8'h5A};
      tbl[2] = '{8'h01, 1'b1, EV_DONE, 8'h01};
      tbl[3] = '{8'h80, 1'b1, EV_DONE, 8'h80};
      tbl[4] = '{8'hFF, 1'b0, EV_FERR, 8'h80};
      tbl[5] = '{8'h00, 1'b1, EV_DONE, 8'h00};

      // Reset
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      repeat (4) @(negedge clk);
      check("reset rx_data", 32'(rx_data), 32'h0);
      check("reset rx_done", 32'(rx_done), 32'h0);
      check("reset frame_err", 32'(frame_err), 32'h0);
      check("reset parity_err", 32'(parity_err), 32'h0);
      obs_q.delete();

      // 0xA5 with latency
      send_frame(8'hA5, 1'b1, -1, 0);
      idle_bits(1);
      model_frame(8'hA5, 1'b1);
      if (obs_q.size() > 0)
         check_range("a5 latency", obs_q[0].cyc - last_start, LAT - 2, LAT + 2);
      compare_events("a5");

      // Back-to-back 0x00, 0xFF with no idle
      send_frame(8'h00, 1'b1, -1, 0);
      send_frame(8'hFF, 1'b1, -1, 0);
      idle_bits(1);
      model_frame(8'h00, 1'b1);
      model_frame(8'hFF, 1'b1);
      if (obs_q.size() > 1)
         check_range("b2b spacing", obs_q[1].cyc - obs_q[0].cyc,
                     FRAME_BITS * BPS - 2, FRAME_BITS * BPS + 2);
      compare_events("b2b");

      // 3-clock low glitch, then 0x3C
      rx_pin = 1'b0;
      repeat (3) @(negedge clk);
      idle_bits(2);
      compare_events("glitch");
      send_frame(8'h3C, 1'b1, -1, 0);
      idle_bits(1);
      model_frame(8'h3C, 1'b1);
      compare_events("after glitch");

      // 0x55 with low stop bit, line held low 40 bit times, then 0x12
      send_frame(8'h55, 1'b0, -1, 0);
      repeat (40 * BPS) @(negedge clk);
      idle_bits(2);
      model_frame(8'h55, 1'b0);
      compare_events("break");
      send_frame(8'h12, 1'b1, -1, 0);
      idle_bits(1);
      model_frame(8'h12, 1'b1);
      compare_events("after break");

      // Disable during data bit 4 of 0x81
      send_frame(8'h81, 1'b1, 5, 1);
      idle_bits(1);
      compare_events("disable");
      check("rx_data held after disable", 32'(rx_data), 32'h12);

      // Reset during data bit 6 of 0xE0 (remaining line bits all high)
      send_frame(8'hE0, 1'b1, 7, 2);
      idle_bits(1);
      compare_events("mid reset");
      check("rx_data after mid reset", 32'(rx_data), 32'h0);
      last_good = 8'h00;
      send_frame(8'h7E, 1'b1, -1, 0);
      idle_bits(1);
      model_frame(8'h7E, 1'b1);
      compare_events("7e");

      // Vector table
      for (int i = 0; i < 6; i++) begin
         ev_t e;
         send_frame(tbl[i].data, tbl[i].stop, -1, 0);
         idle_bits(1);
         e.kind = tbl[i].exp_kind;
         e.data = tbl[i].exp_data;
         e.cyc  = 0;
         exp_q.push_back(e);
         compare_events($sformatf("vec%0d", i));
      end
      last_good = tbl[5].exp_data;

`ifdef RX_PARITY_EN
      par_flip = 1'b0;
      send_frame(8'h03, 1'b1, -1, 0);
      idle_bits(1);
      model_frame(8'h03, 1'b1);
      compare_events("parity ok");
      par_flip = 1'b1;
      send_frame(8'h03, 1'b1, -1, 0);
      idle_bits(1);
      model_frame(8'h03, 1'b1);
      compare_events("parity bad");
      send_frame(8'h44, 1'b0, -1, 0);
      idle_bits(1);
      model_frame(8'h44, 1'b0);
      compare_events("parity and stop bad");
      par_flip = 1'b0;
`endif

      // Randomized frames with random gaps (a low stop bit needs a gap so the
      // next start bit is a real falling edge).
      for (int k = 0; k < 24; k++) begin
         d = 8'($urandom);
         s = ($urandom_range(0, 4) != 0);
`ifdef RX_PARITY_EN
         par_flip = ($urandom_range(0, 3) == 0);
`endif
         send_frame(d, s, -1, 0);
         model_frame(d, s);
         idle_bits(s ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2)));
      end
      idle_bits(1);
      compare_events("random");

      check("pulse overlap or width", 32'(overlap_cnt), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rx_module.md
Name: rx_module

Overview:
- UART receiver; the receive-side counterpart of the team's UART transmitter.
- Samples an asynchronous serial line and recovers 8N1 frames: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Presents each good byte with a one-cycle done pulse to the consuming logic.
- Bit timing comes from a clocks-per-bit parameter; there is no external baud tick.

Parameters:
- BPS, 13'd434: clocks per bit (50 MHz / 115200). Other values: 5208 (50 MHz/9600), 1250 (12 MHz/9600), 104 (12 MHz/115200). Minimum 8.

Ports:
- clk  input  1: system clock.
- rst_n  input  1: synchronous, active-high reset (1 = reset), sampled on posedge clk.
- rx_en_sig  input  1: receive enable; 0 holds the block idle.
- rx_pin  input  1: asynchronous serial line, idle high.
- rx_data  output  8: last correctly framed byte.
- rx_done  output  1: one-cycle pulse when rx_data has been updated.
- frame_err  output  1: one-cycle pulse when the stop bit is sampled as 0.
- parity_err  output  1: one-cycle parity error pulse; constant 0 unless RX_PARITY_EN is defined.

Behaviour:
- Reset values: rx_data=0, rx_done=0, frame_err=0, parity_err=0, FSM=IDLE, bit counter=0, bit index=0, synchroniser flops=1.
- Input path: rx_pin goes through a 2-flop synchroniser, then a third flop for edge detection. A falling edge is sync=0 while the previous value=1.
- Counter c: 16 bits, counts clocks within the current bit. H = BPS>>1 (floor).
- FSM states: IDLE, START, DATA, STOP, DONE.
- IDLE: on a falling edge, go to START with c=0.
- START: c increments each clock. At c==H-1, sample the line:
  - 0: go to DATA with c=0, index=0.
  - 1: treat as a glitch; return to IDLE with no output pulses.
- DATA: at c==BPS-1, shift the sampled bit into shift[index] (LSB first), index+1, c=0. After index 7 is sampled, go to STOP (or PARITY, see Optional Feature).
- STOP: at c==BPS-1, sample the line:
  - 1: rx_data<=shift, go to DONE.
  - 0: frame_err=1 for one cycle, rx_data unchanged, go to IDLE.
- DONE: rx_done=1 for exactly one cycle, then IDLE.
- Ready for the next frame from the midpoint of the stop bit. Back-to-back frames with zero idle time are received.
- Latency: rx_done rises within 9*BPS+H+4 clocks of rx_pin's falling start edge; the bench tolerance is ±2 clocks.
- A stop bit sampled as 0 is a break or line held low. The FSM returns to IDLE and needs a high-to-low transition before it starts again, so a low line does not produce repeated errors.
- rx_en_sig=0: the FSM is forced to IDLE synchronously and c and index are cleared. The in-flight frame is discarded with no pulses, and rx_data holds its value. Reception resumes at the next falling edge after rx_en_sig returns to 1.
- rst_n mid-frame: everything returns to reset values on the next clock. A partially received frame never produces rx_done.
- rx_done, frame_err and parity_err are never high in the same cycle, and each is high for at most 1 cycle per frame.

Optional Feature:
- Macro: RX_PARITY_EN.
- Defined: the frame is 11 bits with an even-parity bit after data bit 7.
  - A PARITY state samples that bit at c==BPS-1.
  - If (^shift ^ bit)==1, the frame is finished and then a parity error is flagged: parity_err pulses 1 cycle in place of rx_done, and rx_data is not updated.
  - A stop-bit error takes priority over a parity error: frame_err only.
- Not defined: 10-bit frame, no PARITY state, parity_err tied to 0.

Test Plan:
- BPS=16. Reset, rx_pin=1, rx_en_sig=1. Send 0xA5 (line bits 0,1,0,1,0,0,1,0,1,1) -> one rx_done pulse within 9*16+8+4±2 clks of the start edge; rx_data=0xA5; frame_err=0.
- Send 0x00 then 0xFF back-to-back with no idle -> two rx_done pulses 160±2 clks apart; rx_data=0x00 and then 0xFF.
- Low glitch of 3 clks on an idle line -> no pulses; FSM back in IDLE; the following 0x3C is received correctly.
- 0x55 with stop bit forced to 0, then line held low for 40 bit times -> exactly one frame_err pulse, rx_data keeps its previous value; the next 0x12 after the line returns high -> rx_done, rx_data=0x12.
- rx_en_sig dropped at data bit 4 of 0x81, and separately rst_n=1 mid-frame -> no rx_done or frame_err from either frame; rx_data is unchanged by the disable and reset to 0 by the reset; the next frame 0x7E is received.
- RX_PARITY_EN defined: 0x03 with parity=0 -> rx_done, rx_data=0x03. 0x03 with parity=1 -> parity_err pulse, no rx_done, rx_data unchanged.
